// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and datapath select codes.
// MC_CTRL_EXT_EN adds the lui immediate type to the ImmSrc helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER, S_EXECUTEI,
    S_JAL, S_ALUWB, S_BEQ, S_ILLEGAL, S_LUI, S_JALR, S_JALR2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd5;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Immediate format depends only on the opcode, so it is valid from DECODE onward.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    logic [2:0] imm;
    imm = IMM_I;
    case (op)
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
`ifdef MC_CTRL_EXT_EN
      OP_LUI:    imm = IMM_U;
`endif
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALUOp/funct to ALUControl decode for the multicycle controller.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            i_alu_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_op5,
  input  logic                  i_funct7b5,
  output logic [ALU_CTRL_W-1:0] o_alu_control
);

  logic [2:0] w_ctrl;

  always_comb begin
    w_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: w_ctrl = ALU_ADD;
      ALUOP_SUB: w_ctrl = ALU_SUB;
      default: begin
        case (i_funct3)
          // Only R-type (op[5]=1) may subtract; addi with instr[30] set is still an add.
          3'b000:  w_ctrl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  w_ctrl = ALU_SLT;
          3'b110:  w_ctrl = ALU_OR;
          3'b111:  w_ctrl = ALU_AND;
          default: w_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

  assign o_alu_control = ALU_CTRL_W'(w_ctrl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM with memory handshake, retired-instruction counter and sticky illegal flag.
// Define MC_CTRL_EXT_EN to add lui, jalr and bne support.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_SRC_W  = 2,
  parameter int CNT_W      = 32,
  parameter int MEM_HS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [IMM_SRC_W-1:0]  ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instret,
  output logic                  illegal
);

  generate
    if (ALU_CTRL_W < 3) begin : g_bad_alu_w
      $error("ALU_CTRL_W must be at least 3");
    end
`ifdef MC_CTRL_EXT_EN
    if (IMM_SRC_W < 3) begin : g_bad_imm_w
      $error("IMM_SRC_W must be at least 3 to encode the U immediate");
    end
`endif
  endgenerate

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_instret;
  logic             r_illegal;

  logic       w_ready, w_taken;
  logic       w_adr_src, w_mem_write, w_ir_write, w_reg_write;
  logic       w_pc_update, w_branch, w_instr_done;
  logic [1:0] w_result_src, w_src_a, w_src_b, w_alu_op;

  assign w_ready = (MEM_HS == 0) ? 1'b1 : mem_ready;

`ifdef MC_CTRL_EXT_EN
  assign w_taken = (funct3 == 3'b001) ? ~zero : zero;
`else
  assign w_taken = zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_instr_done) r_instret <= r_instret + CNT_W'(1);
      if (w_state_next == S_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_instr_done = 1'b0;
    w_result_src = RES_ALUOUT;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_RS2;
    w_alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = w_ready;
        w_pc_update  = w_ready;
        if (w_ready) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut while the opcode is decoded.
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
          OP_RTYPE:          w_state_next = S_EXECUTER;
          OP_ITYPE:          w_state_next = S_EXECUTEI;
          OP_JAL:            w_state_next = S_JAL;
          OP_BRANCH:         w_state_next = S_BEQ;
`ifdef MC_CTRL_EXT_EN
          OP_LUI:            w_state_next = S_LUI;
          OP_JALR:           w_state_next = S_JALR;
`endif
          default:           w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_IMM;
        w_state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        if (w_ready) w_state_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adr_src    = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = w_ready;
        if (w_ready) w_state_next = S_FETCH;
      end
      S_EXECUTER: begin
        w_src_a      = SRCA_RS1;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_IMM;
        w_alu_op     = ALUOP_FUNCT;
        w_state_next = S_ALUWB;
      end
      S_JAL: begin
        w_src_a      = SRCA_OLDPC;
        w_src_b      = SRCB_FOUR;
        w_pc_update  = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BEQ: begin
        w_src_a      = SRCA_RS1;
        w_alu_op     = ALUOP_SUB;
        w_branch     = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end
`ifdef MC_CTRL_EXT_EN
      S_LUI: begin
        w_src_a      = SRCA_ZERO;
        w_src_b      = SRCB_IMM;
        w_state_next = S_ALUWB;
      end
      S_JALR: begin
        w_src_a      = SRCA_RS1;
        w_src_b      = SRCB_IMM;
        w_result_src = RES_ALURESULT;
        w_pc_update  = 1'b1;
        w_state_next = S_JALR2;
      end
      S_JALR2: begin
        w_src_a      = SRCA_OLDPC;
        w_src_b      = SRCB_FOUR;
        w_state_next = S_ALUWB;
      end
`endif
      S_ILLEGAL: w_state_next = S_ILLEGAL;
      default:   w_state_next = S_FETCH;
    endcase
  end

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .i_alu_op     (w_alu_op),
    .i_funct3     (funct3),
    .i_op5        (op[5]),
    .i_funct7b5   (funct7b5),
    .o_alu_control(ALUControl)
  );

  // Write enables are held off combinationally for the whole time reset is asserted.
  assign PCWrite    = rst_n & ((w_branch & w_taken) | w_pc_update);
  assign IRWrite    = rst_n & w_ir_write;
  assign RegWrite   = rst_n & w_reg_write;
  assign MemWrite   = rst_n & w_mem_write;
  assign AdrSrc     = w_adr_src;
  assign ResultSrc  = w_result_src;
  assign ALUSrcA    = w_src_a;
  assign ALUSrcB    = w_src_b;
  assign ImmSrc     = IMM_SRC_W'(imm_src_of(op));
  assign instr_done = w_instr_done;
  assign instret    = r_instret;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit (default build, MC_CTRL_EXT_EN undefined).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  op = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .instr_done(instr_done), .instret(instret), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU-class table: opcode, funct3, funct7b5, expected ALUControl, expected ALUSrcB
  logic [6:0] t_op  [6] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011};
  logic [2:0] t_f3  [6] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b010, 3'b111};
  logic       t_f7  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [2:0] t_ctl [6] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd5, 3'd2};
  logic [1:0] t_srb [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};

  // Branch table: funct3, zero, expected PCWrite in BEQ state
  logic [2:0] b_f3  [3] = '{3'b000, 3'b000, 3'b001};
  logic       b_z   [3] = '{1'b1, 1'b0, 1'b1};
  logic       b_pcw [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    #2;
    chk("rst_pcwrite", 32'(PCWrite), 32'd0);
    chk("rst_irwrite", 32'(IRWrite), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_alusrcb_fetch", 32'(ALUSrcB), 32'd2);
    chk("rst_resultsrc_fetch", 32'(ResultSrc), 32'd2);
    step();
    chk("rst_hold_irwrite", 32'(IRWrite), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(PCWrite), 32'd1);

    for (int i = 0; i < 6; i++) begin
      op = t_op[i]; funct3 = t_f3[i]; funct7b5 = t_f7[i];
      chk("alu_fetch_regwrite", 32'(RegWrite), 32'd0);
      step();
      chk("alu_decode_srca", 32'(ALUSrcA), 32'd1);
      chk("alu_decode_regwrite", 32'(RegWrite), 32'd0);
      step();
      $display("alu instr %0d op=%b f3=%b f7b5=%b ctrl=%0d", i, op, funct3, funct7b5, ALUControl);
      chk("alu_exec_ctrl", 32'(ALUControl), 32'(t_ctl[i]));
      chk("alu_exec_srcb", 32'(ALUSrcB), 32'(t_srb[i]));
      chk("alu_exec_regwrite", 32'(RegWrite), 32'd0);
      step();
      chk("alu_wb_regwrite", 32'(RegWrite), 32'd1);
      chk("alu_wb_done", 32'(instr_done), 32'd1);
      chk("alu_wb_instret_before", instret, 32'(i));
      step();
      chk("alu_instret_after", instret, 32'(i + 1));
      chk("alu_next_done", 32'(instr_done), 32'd0);
    end

    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    step();
    step();
    chk("lw_memadr_srca", 32'(ALUSrcA), 32'd2);
    chk("lw_memadr_srcb", 32'(ALUSrcB), 32'd1);
    chk("lw_immsrc", 32'(ImmSrc), 32'd0);
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("lw_memread_adrsrc", 32'(AdrSrc), 32'd1);
      chk("lw_memread_regwrite", 32'(RegWrite), 32'd0);
      if (c == 3) mem_ready = 1'b1;
    end
    step();
    chk("lw_memwb_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_memwb_resultsrc", 32'(ResultSrc), 32'd1);
    chk("lw_memwb_done", 32'(instr_done), 32'd1);
    step();
    $display("lw retired instret=%0d", instret);
    chk("lw_instret", instret, 32'd7);

    op = 7'b0100011;
    step();
    step();
    chk("sw_immsrc", 32'(ImmSrc), 32'd1);
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("sw_memwrite", 32'(MemWrite), 32'd1);
      chk("sw_regwrite", 32'(RegWrite), 32'd0);
      chk("sw_done", 32'(instr_done), 32'(c == 2));
    end
    step();
    $display("sw retired instret=%0d", instret);
    chk("sw_memwrite_off", 32'(MemWrite), 32'd0);
    chk("sw_instret", instret, 32'd8);

    for (int i = 0; i < 3; i++) begin
      op = 7'b1100011; funct3 = b_f3[i]; zero = b_z[i];
      step();
      chk("br_immsrc", 32'(ImmSrc), 32'd2);
      step();
      $display("branch %0d f3=%b zero=%b pcwrite=%b", i, funct3, zero, PCWrite);
      chk("br_pcwrite", 32'(PCWrite), 32'(b_pcw[i]));
      chk("br_aluctrl_sub", 32'(ALUControl), 32'd1);
      chk("br_done", 32'(instr_done), 32'd1);
      step();
      chk("br_instret", instret, 32'(9 + i));
    end
    zero = 1'b0; funct3 = 3'b000;

    op = 7'b1101111;
    step();
    chk("jal_immsrc", 32'(ImmSrc), 32'd3);
    step();
    chk("jal_pcwrite", 32'(PCWrite), 32'd1);
    chk("jal_srca", 32'(ALUSrcA), 32'd1);
    chk("jal_srcb", 32'(ALUSrcB), 32'd2);
    step();
    chk("jal_wb_regwrite", 32'(RegWrite), 32'd1);
    step();
    $display("jal retired instret=%0d", instret);
    chk("jal_instret", instret, 32'd12);

    op = 7'b0110011;
    step();
    step();
    chk("midrst_exec_srca", 32'(ALUSrcA), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted in EXECUTER");
    chk("midrst_srcb_fetch", 32'(ALUSrcB), 32'd2);
    chk("midrst_irwrite", 32'(IRWrite), 32'd0);
    chk("midrst_pcwrite", 32'(PCWrite), 32'd0);
    chk("midrst_regwrite", 32'(RegWrite), 32'd0);
    chk("midrst_instret", instret, 32'd0);
    step();
    chk("midrst_hold_pcwrite", 32'(PCWrite), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_irwrite", 32'(IRWrite), 32'd1);

    op = 7'b0110111;
    step();
    chk("lui_decode_illegal", 32'(illegal), 32'd0);
    step();
    chk("lui_not_supported", 32'(illegal), 32'd1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("lui_rst_illegal", 32'(illegal), 32'd0);

    op = 7'b1111111;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite, instr_done}), 32'd0);
      chk("ill_instret", instret, 32'd0);
      step();
    end
    $display("illegal held for 10 cycles");
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("ill_rst_flag", 32'(illegal), 32'd0);
    chk("ill_rst_instret", instret, 32'd0);
    chk("ill_rst_srcb_fetch", 32'(ALUSrcB), 32'd2);
    chk("ill_rst_irwrite", 32'(IRWrite), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle RV32I controller: a registered FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Its outputs drive the shared-memory multicycle datapath. It replaces the single-cycle decoder pair.
- Adds a memory ready handshake, a retired-instruction counter and sticky illegal-opcode detection.

Parameters:
- ALU_CTRL_W, 3: ALUControl width. Must be >=3.
- IMM_SRC_W, 2: ImmSrc width. Must be >=3 when MC_CTRL_EXT_EN is defined; otherwise elaboration fails via $error.
- CNT_W, 32: width of the retired-instruction counter.
- MEM_HS, 1: 1 means memory states wait for mem_ready; 0 means mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode, taken from the instruction register and stable after FETCH.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- PCWrite  out  1  equals (Branch & taken) | PCUpdate.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register load.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4.
- ImmSrc  out  IMM_SRC_W  I = 0, S = 1, B = 2, J = 3, U = 4.
- ALUControl  out  ALU_CTRL_W  add = 0, sub = 1, and = 2, or = 3, slt = 5.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instret  out  CNT_W  retired-instruction count.
- illegal  out  1  sticky unsupported-opcode flag.

Behaviour:
- Reset (async, rst_n=0):
  - state = FETCH, instret = 0, illegal = 0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while rst_n is low. Other outputs take the FETCH decode.
  - Reset mid-instruction abandons the instruction. No counter increment.
- Outputs are Moore: decoded from state. Exceptions:
  - PCWrite, which uses zero.
  - Gating by mem_ready.
  - ImmSrc, which is combinational from op.
- ALUOp (internal): 00 = add, 01 = sub, 10 = funct decode.
- Funct decode:
  - funct3 000: sub if {op[5], funct7b5} == 11, else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - Any other funct3: add.
- States (outputs not listed are 0 / don't-care):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stays in FETCH while !mem_ready; on mem_ready -> DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - else -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Waits for mem_ready, then -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held every cycle until mem_ready -> FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; taken = zero -> FETCH.
  - ILLEGAL: all enables 0. illegal is set to 1 and the FSM stays here until reset.
- instr_done: asserted in the last cycle of each instruction (MEMWB, ALUWB, BEQ, MEMWRITE with mem_ready). instret increments on the same edge and wraps modulo 2^CNT_W.
- MEM_HS=0: every mem-wait state advances after one cycle.

Optional Feature:
- MC_CTRL_EXT_EN defined: adds three instructions.
  - lui 0110111: ImmSrc=4, DECODE -> LUI state (ALUSrcA=11, ALUSrcB=01, ALUOp=00) -> ALUWB.
  - jalr 1100111: JALR state (ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCUpdate=1) -> JALR2 (ALUSrcA=01, ALUSrcB=10, ALUOp=00) -> ALUWB.
  - bne: in the BEQ state, taken = funct3==001 ? !zero : zero.
- MC_CTRL_EXT_EN undefined: 0110111 and 1100111 go to ILLEGAL. bne behaves as beq.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State enum.
  - Opcode localparams.
  - ALUOp, ALUControl, ResultSrc, ALUSrcA/B and ImmSrc encodings.
- Sub-module mc_alu_decoder holds the combinational ALUOp/funct -> ALUControl logic.

Test Plan:
- R-type add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> 4 cycles: FETCH, DECODE, EXECUTER, ALUWB. RegWrite=1 only in cycle 4; instr_done pulses; instret 0 -> 1.
- lw with mem_ready low for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles, then MEMWB with RegWrite=1. Total 8 cycles.
- sw, mem_ready delayed 2 cycles -> MemWrite high for exactly 3 cycles. RegWrite never asserted.
- beq with zero=1 -> PCWrite=1 in the BEQ cycle. With zero=0 -> PCWrite=0. Both cases increment instret.
- op 1111111 -> ILLEGAL. illegal=1 and stays set; no enables for 10 cycles. rst_n pulse -> FETCH, illegal=0, instret=0.
- rst_n dropped in EXECUTER -> async return to FETCH. Enables 0 during reset; instret unchanged from 0.
